// File: rtl/asyn_fifo_rd_stream_if.sv
// Bundle of the FIFO read-port and downstream stream signals for asyn_fifo_rd_stream.
// master: the read-stream block (drives pop, stream valid/data, level).
// slave: the surrounding FIFO/consumer environment.
interface asyn_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_ren;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            buf_level;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_ren, m_valid, m_data, buf_level
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_ren, m_valid, m_data, buf_level
  );
endinterface

// File: rtl/asyn_fifo_rd_stream.sv
// Pops the async FIFO read port and re-presents the data as a valid/ready stream.
// Latency: pop at edge N, word captured at edge N+1, m_valid high from cycle N+1.
// Backpressure: 2-entry skid buffer; pops stop once buffered + in-flight words reach 2.
// Optional word counter (rd_word_cnt / cnt_clr) enabled by ASYN_FIFO_RD_STREAM_CNT_EN.
module asyn_fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    read_clk,
  input  logic                    read_rst_n,
`ifdef ASYN_FIFO_RD_STREAM_CNT_EN
  input  logic                    cnt_clr,
  output logic [15:0]             rd_word_cnt,
`endif
  asyn_fifo_rd_stream_if.master   bus
);

  // FIFO depth behind this block; only used to sanity-check the buffer bound.
  localparam int unsigned FIFO_DEPTH = 2 ** ADDR_WIDTH;

  logic [1:0]            occ;
  logic                  inflight;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] entry [2];

  logic                  m_valid_int;
  logic                  xfer;
  logic                  pop;
  logic                  ren;
  logic [2:0]            occ_sum;

  // Words that will be held after this edge; pop only if that leaves room for one more.
  always_comb begin
    m_valid_int = (occ != 2'd0);
    xfer        = m_valid_int & bus.m_ready;
    occ_sum     = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    // Gated by reset so no word is pulled out of the FIFO while this block is held.
    ren         = read_rst_n & (occ_sum < 3'd2);
    pop         = ren & ~bus.fifo_empty;
  end

  assign bus.fifo_ren  = ren;
  assign bus.m_valid   = m_valid_int;
  assign bus.m_data    = entry[head];
  assign bus.buf_level = occ;

  // Occupancy, in-flight flag and ring pointers; RAM data arrives one cycle after the pop.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry[i] <= '0;
      end
    end else begin
      occ      <= occ_sum[1:0];
      inflight <= pop;
      if (inflight) begin
        entry[tail] <= bus.fifo_rdata;
        tail        <= ~tail;
      end
      if (xfer) begin
        head <= ~head;
      end
    end
  end

`ifdef ASYN_FIFO_RD_STREAM_CNT_EN
  // Count accepted stream words; a clear wins over an increment in the same cycle.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      rd_word_cnt <= 16'd0;
    end else if (cnt_clr) begin
      rd_word_cnt <= 16'd0;
    end else if (xfer) begin
      rd_word_cnt <= rd_word_cnt + 16'd1;
    end
  end
`endif

  // The skid buffer can never hold more than two words, nor more than the FIFO itself.
  assert property (@(posedge read_clk) disable iff (!read_rst_n)
                   (occ <= 2'd2) && (32'(occ) <= FIFO_DEPTH));

endmodule
